// File: rtl/varint_field_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// varint_pkg
// Shared types, sizes and varint helper functions for varint_field_scheduler
// and its encoder.
//   field_req_t    : one latched {value, field_id, field_type} request
//   sched_state_e  : scheduler FSM states
//   varint_bytes() : LEB128 bytes of a 64-bit value, LSB byte first, zero padded
//   varint_len()   : number of significant bytes in that encoding (1..10)
// -----------------------------------------------------------------------------
package varint_pkg;

   localparam int ENC_W         = 120;
   localparam int MAX_ENC_BYTES = 15;
   localparam int MAX_TAG_BYTES = 5;

   localparam logic [4:0] TYPE_SINT32 = 5'd17;
   localparam logic [4:0] TYPE_SINT64 = 5'd18;
   localparam logic [2:0] WIRE_VARINT = 3'd0;

   typedef struct packed {
      logic [63:0] value;
      logic [28:0] field_id;
      logic [4:0]  field_type;
   } field_req_t;

   typedef enum logic [1:0] {IDLE, ENC, EMIT} sched_state_e;

   // Bytes after the terminating byte come out as 8'h00 because the
   // remaining value is zero by then.
   function automatic logic [79:0] varint_bytes(input logic [63:0] v);
      logic [63:0] rem;
      logic [79:0] res;
      rem = v;
      res = '0;
      for (int k = 0; k < 10; k++) begin
         res[8*k +: 7] = rem[6:0];
         rem           = rem >> 7;
         res[8*k + 7]  = (rem != 64'h0);
      end
      return res;
   endfunction

   function automatic logic [3:0] varint_len(input logic [63:0] v);
      logic [3:0] n;
      n = 4'd1;
      for (int k = 1; k < 10; k++) begin
         if ((v >> (7*k)) != 64'h0) n = 4'(k + 1);
      end
      return n;
   endfunction

endpackage

// File: rtl/top_varint.sv
// -----------------------------------------------------------------------------
// top_varint
// Combinational protobuf field encoder: tag varint ((field_id<<3)|wire type 0)
// followed by the value varint, LSB byte first, zero padded to 120 bits.
// Field types 17 (sint32) and 18 (sint64) are zigzag-mapped first.
//   i_value      in  64   raw field value
//   i_field_id   in  29   protobuf field number
//   i_field_type in  5    protobuf TYPE_* code
//   o_out_port   out 120  tag bytes then value bytes
// -----------------------------------------------------------------------------
module top_varint
   import varint_pkg::*;
(
   input  logic [63:0]      i_value,
   input  logic [28:0]      i_field_id,
   input  logic [4:0]       i_field_type,
   output logic [ENC_W-1:0] o_out_port
);

   logic [63:0] w_payload;
   logic [63:0] w_tag_int;
   logic [79:0] w_tag_bytes;
   logic [79:0] w_val_bytes;
   logic [3:0]  w_tag_len;

   always_comb begin
      w_payload = i_value;
      if (i_field_type == TYPE_SINT32)
         w_payload = {32'h0, {i_value[30:0], 1'b0} ^ {32{i_value[31]}}};
      else if (i_field_type == TYPE_SINT64)
         w_payload = {i_value[62:0], 1'b0} ^ {64{i_value[63]}};
      w_tag_int   = {32'h0, i_field_id, WIRE_VARINT};
      w_tag_bytes = varint_bytes(w_tag_int);
      w_val_bytes = varint_bytes(w_payload);
      w_tag_len   = varint_len(w_tag_int);
      // The tag never exceeds MAX_TAG_BYTES, so only its low 40 bits matter.
      o_out_port  = {80'h0, w_tag_bytes[8*MAX_TAG_BYTES-1:0]}
                  | ({40'h0, w_val_bytes} << (8 * w_tag_len));
   end

endmodule

// File: rtl/varint_rr_arbiter.sv
// -----------------------------------------------------------------------------
// varint_rr_arbiter
// Combinational round-robin pick: grants the first asserted request at or
// after i_ptr, wrapping modulo NUM_REQ.
//   i_req   in  NUM_REQ  pending requests
//   i_ptr   in  SRC_W    highest-priority index this cycle
//   o_grant out NUM_REQ  one-hot grant (all zero when nothing pending)
//   o_idx   out SRC_W    index of the granted request
//   o_any   out 1        at least one request pending
// -----------------------------------------------------------------------------
module varint_rr_arbiter #(
   parameter  int NUM_REQ = 4,
   localparam int SRC_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [SRC_W-1:0]   i_ptr,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [SRC_W-1:0]   o_idx,
   output logic               o_any
);

   int               w_j;
   logic [SRC_W-1:0] w_j_idx;

   // NOTE: every signal driven here gets a default before the loop so no
   // path leaves it unassigned; that is what keeps this block latch-free.
   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      w_j     = 0;
      w_j_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_j = int'(i_ptr) + k;
         if (w_j >= NUM_REQ) w_j = w_j - NUM_REQ;
         w_j_idx = SRC_W'(w_j);
         if (!o_any && i_req[w_j_idx]) begin
            o_any            = 1'b1;
            o_grant[w_j_idx] = 1'b1;
            o_idx            = w_j_idx;
         end
      end
   end

endmodule

// File: rtl/varint_field_scheduler.sv
// -----------------------------------------------------------------------------
// varint_field_scheduler
// Shares one top_varint encoder between NUM_REQ field producers. A round-robin
// grant latches one request, the next cycle registers its encoding, then the
// tag+varint bytes stream out LSB first on a valid/ready byte bus.
// Optional build macro: VARINT_SCHED_SKIP_ZERO_EN -- when defined, a request
// whose value is zero is consumed without emitting any bytes.
//   clk              in   1           rising-edge clock
//   rst              in   1           synchronous active-high reset
//   i_req_valid      in   NUM_REQ     per-requester pending flag
//   o_req_ready      out  NUM_REQ     one-hot grant, only while IDLE
//   i_req_value      in   NUM_REQ*64  slice i = [64*i+:64]
//   i_req_field_id   in   NUM_REQ*29  slice i = [29*i+:29]
//   i_req_field_type in   NUM_REQ*5   slice i = [5*i+:5]
//   o_out_data       out  8           encoded byte
//   o_out_valid      out  1           o_out_data valid
//   i_out_ready      in   1           downstream accepts byte
//   o_out_last       out  1           final byte of the current field
//   o_out_src        out  SRC_W       requester index of the current field
//   o_busy           out  1           FSM not in IDLE
// -----------------------------------------------------------------------------
module varint_field_scheduler
   import varint_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int SRC_W   = $clog2(NUM_REQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    i_req_valid,
   output logic [NUM_REQ-1:0]    o_req_ready,
   input  logic [NUM_REQ*64-1:0] i_req_value,
   input  logic [NUM_REQ*29-1:0] i_req_field_id,
   input  logic [NUM_REQ*5-1:0]  i_req_field_type,
   output logic [7:0]            o_out_data,
   output logic                  o_out_valid,
   input  logic                  i_out_ready,
   output logic                  o_out_last,
   output logic [SRC_W-1:0]      o_out_src,
   output logic                  o_busy
);

   sched_state_e     r_state;
   logic [SRC_W-1:0] r_rr_ptr;
   logic [SRC_W-1:0] r_src;
   field_req_t       r_req;
   logic [ENC_W-1:0] r_sr;
   logic [3:0]       r_len;
   logic [3:0]       r_cnt;
   logic             r_out_valid;
   logic             r_out_last;

   logic [NUM_REQ-1:0] w_grant;
   logic [SRC_W-1:0]   w_grant_idx;
   logic               w_any;
   logic [SRC_W-1:0]   w_ptr_next;
   field_req_t         w_sel;
   logic [ENC_W-1:0]   w_enc;
   logic [3:0]         w_enc_len;
   logic [1:0]         w_term_cnt;
   logic               w_skip;

   varint_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .i_req   (i_req_valid),
      .i_ptr   (r_rr_ptr),
      .o_grant (w_grant),
      .o_idx   (w_grant_idx),
      .o_any   (w_any)
   );

   assign w_sel.value      = i_req_value[64*w_grant_idx +: 64];
   assign w_sel.field_id   = i_req_field_id[29*w_grant_idx +: 29];
   assign w_sel.field_type = i_req_field_type[5*w_grant_idx +: 5];
   assign w_ptr_next       = (w_grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;

   top_varint u_enc (
      .i_value      (r_req.value),
      .i_field_id   (r_req.field_id),
      .i_field_type (r_req.field_type),
      .o_out_port   (w_enc)
   );

   // Total length ends at the second byte with bit7 clear: the first one
   // closes the tag, the second closes the value.
   always_comb begin
      w_enc_len  = 4'd0;
      w_term_cnt = 2'd0;
      for (int k = 0; k < MAX_ENC_BYTES; k++) begin
         if (!w_enc[8*k + 7] && (w_term_cnt < 2'd2)) begin
            w_term_cnt = w_term_cnt + 2'd1;
            if (w_term_cnt == 2'd2) w_enc_len = 4'(k + 1);
         end
      end
   end

`ifdef VARINT_SCHED_SKIP_ZERO_EN
   assign w_skip = (r_req.value == 64'h0);
`else
   assign w_skip = 1'b0;
`endif

   // Grant is combinational but masked outside IDLE and during reset.
   assign o_req_ready = (r_state == IDLE && !rst) ? w_grant : '0;
   assign o_out_valid = r_out_valid;
   assign o_out_data  = r_sr[7:0];
   assign o_out_last  = r_out_last;
   assign o_out_src   = r_src;
   assign o_busy      = (r_state != IDLE);

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_rr_ptr    <= '0;
         r_src       <= '0;
         r_req       <= '0;
         r_sr        <= '0;
         r_len       <= 4'd0;
         r_cnt       <= 4'd0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_req    <= w_sel;
                  r_src    <= w_grant_idx;
                  r_rr_ptr <= w_ptr_next;
                  r_state  <= ENC;
               end
            end
            ENC: begin
               if (w_skip) begin
                  r_state <= IDLE;
               end else begin
                  r_sr        <= w_enc;
                  r_len       <= w_enc_len;
                  r_cnt       <= 4'd0;
                  r_out_valid <= 1'b1;
                  r_out_last  <= 1'b0;  // len is always >= 2
                  r_state     <= EMIT;
               end
            end
            EMIT: begin
               if (i_out_ready) begin
                  if (r_out_last) begin
                     r_out_valid <= 1'b0;
                     r_out_last  <= 1'b0;
                     r_state     <= IDLE;
                  end else begin
                     r_sr       <= r_sr >> 8;
                     r_cnt      <= r_cnt + 4'd1;
                     r_out_last <= (r_cnt + 4'd2 == r_len);
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_varint_field_scheduler.sv
// -----------------------------------------------------------------------------
// tb_varint_field_scheduler
// Directed bench for varint_field_scheduler (NUM_REQ=4): protobuf encodings,
// round-robin order, backpressure hold, reset mid-field and zero-value fields.
// -----------------------------------------------------------------------------
module tb_varint_field_scheduler;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   req_valid;
   logic [3:0]   req_ready;
   logic [255:0] req_value;
   logic [115:0] req_field_id;
   logic [19:0]  req_field_type;
   logic [7:0]   out_data;
   logic         out_valid;
   logic         out_ready;
   logic         out_last;
   logic [1:0]   out_src;
   logic         busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   varint_field_scheduler #(.NUM_REQ(4)) dut (
      .clk              (clk),
      .rst              (rst),
      .i_req_valid      (req_valid),
      .o_req_ready      (req_ready),
      .i_req_value      (req_value),
      .i_req_field_id   (req_field_id),
      .i_req_field_type (req_field_type),
      .o_out_data       (out_data),
      .o_out_valid      (out_valid),
      .i_out_ready      (out_ready),
      .o_out_last       (out_last),
      .o_out_src        (out_src),
      .o_busy           (busy)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int idx, input logic [63:0] v, input logic [28:0] id,
                          input logic [4:0] ty);
      req_value[64*idx +: 64]     = v;
      req_field_id[29*idx +: 29]  = id;
      req_field_type[5*idx +: 5]  = ty;
   endtask

   // Raises one request in IDLE, checks the grant, drops it after the grant edge.
   task automatic issue(input int idx, input logic [63:0] v, input logic [28:0] id,
                        input logic [4:0] ty, input logic [3:0] gnt);
      set_req(idx, v, id, ty);
      req_valid[idx] = 1'b1;
      #1;
      check("grant", req_ready, gnt);
      step();
      req_valid[idx] = 1'b0;
      #1;
      check("ready_after_grant", req_ready, 4'b0000);
      check("valid_in_enc", out_valid, 1'b0);
      check("busy_in_enc", busy, 1'b1);
   endtask

   // Receives n bytes (stream byte k = stream[8k+:8]); toggle alternates
   // out_ready 0/1 starting with a stall and checks outputs hold while stalled.
   task automatic recv(input logic [119:0] stream, input int n, input logic [1:0] src,
                       input bit toggle);
      int         got;
      int         cyc;
      bit         stalled;
      bit         ph;
      logic [7:0] sd;
      logic       sl;
      got = 0; cyc = 0; stalled = 0; ph = 0; sd = '0; sl = 1'b0;
      while (got < n && cyc < 100) begin
         if (out_valid) begin
            if (stalled) begin
               check("hold_data", out_data, sd);
               check("hold_last", out_last, sl);
               check("hold_src", out_src, src);
            end
            out_ready = toggle ? ph : 1'b1;
            ph = ~ph;
            if (out_ready) begin
               check("data", out_data, stream[8*got +: 8]);
               check("last", out_last, (got == n - 1));
               check("src", out_src, src);
               got++;
               stalled = 0;
            end else begin
               sd = out_data;
               sl = out_last;
               stalled = 1;
            end
         end
         step();
         cyc++;
      end
      check("byte_count", got, n);
      out_ready = 1'b1;
      check("idle_valid", out_valid, 1'b0);
      check("idle_busy", busy, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      logic [3:0] g;
      rst            = 1'b1;
      req_valid      = 4'hF;
      req_value      = '0;
      req_field_id   = '0;
      req_field_type = '0;
      out_ready      = 1'b1;

      // Reset state, with every requester asserting.
      step();
      step();
      check("rst_ready", req_ready, 4'b0000);
      check("rst_valid", out_valid, 1'b0);
      check("rst_last", out_last, 1'b0);
      check("rst_data", out_data, 8'h00);
      check("rst_src", out_src, 2'd0);
      check("rst_busy", busy, 1'b0);
      req_valid = 4'h0;
      rst = 1'b0;
      step();

      // T1: 150, id 1, int32 -> 08 96 01, first byte two cycles after grant.
      issue(0, 64'd150, 29'd1, 5'd5, 4'b0001);
      step();
      check("t1_latency", out_valid, 1'b1);
      recv(120'h01_96_08, 3, 2'd0, 1'b0);

      // T2: -2 sint64 zigzag -> 10 03.
      issue(1, 64'hFFFF_FFFF_FFFF_FFFE, 29'd2, 5'd18, 4'b0010);
      recv(120'h03_10, 2, 2'd1, 1'b0);

      // T3: -2 int32 -> ten-byte value, 11 bytes total.
      issue(2, 64'hFFFF_FFFF_FFFF_FFFE, 29'd2, 5'd5, 4'b0100);
      recv(120'h01_FF_FF_FF_FF_FF_FF_FF_FF_FE_10, 11, 2'd2, 1'b0);

      // T5: T1 under alternating backpressure.
      issue(0, 64'd150, 29'd1, 5'd5, 4'b0001);
      recv(120'h01_96_08, 3, 2'd0, 1'b1);

      // T6: reset while the second byte of T3's encoding is on the bus.
      issue(2, 64'hFFFF_FFFF_FFFF_FFFE, 29'd2, 5'd5, 4'b0100);
      step();
      check("t6_b0_valid", out_valid, 1'b1);
      check("t6_b0_data", out_data, 8'h10);
      step();
      check("t6_b1_data", out_data, 8'hFE);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("t6_valid", out_valid, 1'b0);
      check("t6_busy", busy, 1'b0);
      check("t6_last", out_last, 1'b0);
      check("t6_src", out_src, 2'd0);
      check("t6_data", out_data, 8'h00);
      issue(3, 64'd150, 29'd1, 5'd5, 4'b1000);
      recv(120'h01_96_08, 3, 2'd3, 1'b0);

      // T4: all four held high -> grants 0,1,2,3,0, each a one-cycle pulse.
      for (int r = 0; r < 4; r++) set_req(r, 64'd1, 29'd1, 5'd0);
      req_valid = 4'hF;
      for (int i = 0; i < 5; i++) begin
         g = 4'b0001 << (i % 4);
         #1;
         check("t4_grant", req_ready, g);
         step();
         if (i == 4) req_valid = 4'h0;
         check("t4_pulse", req_ready, 4'b0000);
         recv(120'h01_08, 2, 2'(i % 4), 1'b0);
      end

      // T7: zero value, id 1.
      issue(1, 64'd0, 29'd1, 5'd0, 4'b0010);
`ifdef VARINT_SCHED_SKIP_ZERO_EN
      step();
      check("t7_skip_valid", out_valid, 1'b0);
      check("t7_skip_busy", busy, 1'b0);
`else
      recv(120'h00_08, 2, 2'd1, 1'b0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
